// File: rtl/sig_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package sig_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } sig_state_t;

    // Step counter width: enough for 0..w-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        int c;
        c = $clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/sig_neg.sv
// Conditional two's-complement negator: oY = iNeg ? -iX : iX.
module sig_neg #(
    parameter int W = 4
) (
    input  logic         iNeg,
    input  logic [W-1:0] iX,
    output logic [W-1:0] oY
);

    assign oY = iNeg ? -iX : iX;

endmodule

// File: rtl/sig_seq_mul.sv
// Multi-cycle signed/unsigned shift-add multiplier with valid/ready handshakes
// on both sides; one partial-product step per clock.
module sig_seq_mul
    import sig_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iValid,
    output logic               oReady,
    input  logic               iSigned,
    input  logic [WIDTH-1:0]   iX1,
    input  logic [WIDTH-1:0]   iX2,
    output logic               oValid,
    input  logic               iReady,
    output logic [2*WIDTH-1:0] oY
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sig_state_t         state_q, state_d;
    logic [2*WIDTH:0]   acc_q, acc_step;
    logic [WIDTH-1:0]   mcand_q, mplier_q;
    logic [WIDTH-1:0]   mag1, mag2, addend;
    logic [WIDTH:0]     upper;
    logic [2*WIDTH-1:0] prod, y_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;

    sig_neg #(.W(WIDTH)) u_mag1 (
        .iNeg (iSigned & iX1[WIDTH-1]),
        .iX   (iX1),
        .oY   (mag1)
    );

    sig_neg #(.W(WIDTH)) u_mag2 (
        .iNeg (iSigned & iX2[WIDTH-1]),
        .iX   (iX2),
        .oY   (mag2)
    );

    // Add into the upper half (carry lands in the extra top bit), then shift.
    assign addend   = mplier_q[0] ? mcand_q : '0;
    assign upper    = acc_q[2*WIDTH:WIDTH] + {1'b0, addend};
    assign acc_step = {upper, acc_q[WIDTH-1:0]} >> 1;

    sig_neg #(.W(2 * WIDTH)) u_fix (
        .iNeg (neg_q),
        .iX   (acc_step[2*WIDTH-1:0]),
        .oY   (prod)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (iValid) state_d = CALC;
            CALC:    if (cnt_q == LAST) state_d = DONE;
            DONE:    if (iReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            y_q      <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (iValid) begin
                        mcand_q  <= mag1;
                        mplier_q <= mag2;
                        neg_q    <= iSigned & (iX1[WIDTH-1] ^ iX2[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                CALC: begin
                    acc_q    <= acc_step;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) y_q <= prod;
                end
                default: ;
            endcase
        end
    end

    assign oReady = (state_q == IDLE);
    assign oValid = (state_q == DONE);
    assign oY     = y_q;

endmodule

// File: tb/tb_sig_seq_mul.sv
// Randomized and directed self-checking bench for sig_seq_mul at WIDTH=4 and WIDTH=8.
module tb_sig_seq_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v4, rdy4, s4, ordy4, ovld4;
    logic [3:0] x1_4, x2_4;
    logic [7:0] y4;
    logic       v8, rdy8, s8, ordy8, ovld8;
    logic [7:0] x1_8, x2_8;
    logic [15:0] y8;

    int errors = 0;
    int checks = 0;

    sig_seq_mul #(.WIDTH(4)) dut4 (
        .iClk(clk), .iRst_n(rst_n), .iValid(v4), .oReady(ordy4), .iSigned(s4),
        .iX1(x1_4), .iX2(x2_4), .oValid(ovld4), .iReady(rdy4), .oY(y4)
    );

    sig_seq_mul #(.WIDTH(8)) dut8 (
        .iClk(clk), .iRst_n(rst_n), .iValid(v8), .oReady(ordy8), .iSigned(s8),
        .iX1(x1_8), .iX2(x2_8), .oValid(ovld8), .iReady(rdy8), .oY(y8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer product truncated to 2*w bits.
    function automatic logic [63:0] model(input int w, input bit sgn,
                                          input logic [63:0] a, input logic [63:0] b);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic run4(input bit sgn, input logic [3:0] a, input logic [3:0] b,
                        input logic [63:0] exp, input int bp, input string tag);
        int n;
        s4 = sgn; x1_4 = a; x2_4 = b; v4 = 1'b1; rdy4 = (bp == 0);
        chk({tag, "_rdy_idle"}, ordy4, 1);
        @(posedge clk); #1;
        n = 0;
        while (!ovld4 && n < 12) begin
            chk({tag, "_rdy_busy"}, ordy4, 0);
            v4 = 1'($urandom); x1_4 = 4'($urandom); x2_4 = 4'($urandom); s4 = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_y"}, y4, exp);
        repeat (bp) begin
            v4 = 1'($urandom); x1_4 = 4'($urandom);
            @(posedge clk); #1;
            chk({tag, "_bp_vld"}, ovld4, 1);
            chk({tag, "_bp_y"}, y4, exp);
            chk({tag, "_bp_rdy"}, ordy4, 0);
        end
        v4 = 1'b0; rdy4 = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_vld_after"}, ovld4, 0);
        chk({tag, "_rdy_after"}, ordy4, 1);
    endtask

    task automatic run8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                        input logic [63:0] exp, input string tag);
        int n;
        s8 = sgn; x1_8 = a; x2_8 = b; v8 = 1'b1; rdy8 = 1'b1;
        chk({tag, "_rdy_idle"}, ordy8, 1);
        @(posedge clk); #1;
        v8 = 1'b0; x1_8 = 8'($urandom); x2_8 = 8'($urandom);
        n = 0;
        while (!ovld8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_y"}, y8, exp);
        @(posedge clk); #1;
        chk({tag, "_rdy_after"}, ordy8, 1);
    endtask

    task automatic back_to_back();
        logic [63:0] q[$];
        int issued, done, last_acc, cyc;
        bit acc, fin;
        issued = 0; done = 0; last_acc = -1; cyc = 0;
        rdy4 = 1'b1;
        s4 = 1'($urandom); x1_4 = 4'($urandom); x2_4 = 4'($urandom); v4 = 1'b1;
        while (done < 10 && cyc < 300) begin
            acc = v4 && ordy4;
            fin = ovld4 && rdy4;
            if (fin) begin
                if (q.size() == 0) chk("b2b_spurious_valid", 1, 0);
                else chk("b2b_y", y4, q.pop_front());
                done++;
            end
            if (acc) begin
                q.push_back(model(4, s4, 64'(x1_4), 64'(x2_4)));
                if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, 6);
                last_acc = cyc;
                issued++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (issued < 10) begin
                    s4 = 1'($urandom); x1_4 = 4'($urandom); x2_4 = 4'($urandom);
                end else begin
                    v4 = 1'b0;
                end
            end
        end
        chk("b2b_count", done, 10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        v4 = 0; rdy4 = 0; s4 = 0; x1_4 = '0; x2_4 = '0;
        v8 = 0; rdy8 = 0; s8 = 0; x1_8 = '0; x2_8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst4_rdy", ordy4, 1);
        chk("rst4_vld", ovld4, 0);
        chk("rst4_y", y4, 0);
        chk("rst8_rdy", ordy8, 1);
        chk("rst8_vld", ovld8, 0);
        chk("rst8_y", y8, 0);
        rst_n = 1'b1;

        run4(0, 4'hF, 4'hF, 64'hE1, 0, "u_f_f");
        run4(1, 4'h8, 4'h7, 64'hC8, 0, "s_8_7");
        run4(1, 4'h8, 4'h8, 64'h40, 0, "s_8_8");
        run4(1, 4'hF, 4'hF, 64'h01, 0, "s_f_f");

        run4(0, 4'h3, 4'h5, 64'h0F, 5, "hs_3_5");

        // Reset lands on the second CALC edge of an in-flight 5*7.
        s4 = 0; x1_4 = 4'h5; x2_4 = 4'h7; v4 = 1'b1; rdy4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_vld", ovld4, 0);
        chk("midrst_rdy", ordy4, 1);
        chk("midrst_y", y4, 0);
        run4(0, 4'h2, 4'h3, 64'h06, 0, "after_rst");

        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run4(bit'(m), 4'(a), 4'(b), model(4, bit'(m), 64'(a), 64'(b)), 0, "exh");

        back_to_back();

        run8(1, 8'h80, 8'h80, 64'h4000, "w8_s_80_80");
        run8(1, 8'h80, 8'h7F, 64'hC080, "w8_s_80_7f");
        run8(0, 8'hFF, 8'hFF, 64'hFE01, "w8_u_ff_ff");
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a, b;
            bit sg;
            a = 8'($urandom); b = 8'($urandom); sg = 1'($urandom);
            run8(sg, a, b, model(8, sg, 64'(a), 64'(b)), "w8_rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
